// File: rtl/n3l_pair_queue.sv
// Pair queue after the Newton's-third-law filter. It keeps the surviving (reference, neighbor)
// pairs in a first-word-fall-through circular buffer and turns a dropped sweep end into a marker entry.
module n3l_pair_queue #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_reference,
  input  logic [DATA_W-1:0] in_neighbor,
  input  logic              in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_reference,
  output logic [DATA_W-1:0] out_neighbor,
  output logic              out_pair_valid,
  output logic              out_last,
  output logic [ADDR_W:0]   count,
  output logic [31:0]       accepted_cnt,
  output logic [31:0]       dropped_cnt,
  output logic              done
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned STAT_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] reference;
    logic [DATA_W-1:0] neighbor;
    logic              pair_valid;
    logic              last;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             wr_entry;
  entry_t             head;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]   occ;
  logic               push_fire;
  logic               push_en;
  logic               pop_en;

  // Handshake decode. A rejected pair with in_last set still takes a slot as a marker.
  always_comb begin
    in_ready  = (occ != CNT_W'(DEPTH));
    out_valid = (occ != '0);
    push_fire = in_valid && in_ready;
    push_en   = push_fire && (in_keep || in_last);
    pop_en    = out_valid && out_ready;
  end

  always_comb begin
    wr_entry            = '0;
    wr_entry.reference  = in_reference;
    wr_entry.neighbor   = in_neighbor;
    wr_entry.pair_valid = in_keep;
    wr_entry.last       = in_last;
  end

  // Storage is left uninitialised on reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // The head is presented straight from storage (fall-through).
  always_comb begin
    head           = mem[rd_ptr];
    out_reference  = head.reference;
    out_neighbor   = head.neighbor;
    out_pair_valid = head.pair_valid;
    out_last       = head.last;
    count          = occ;
  end

  // Pointers wrap naturally because DEPTH is 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push_en && !pop_en) begin
        occ <= occ + CNT_W'(1);
      end else if (pop_en && !push_en) begin
        occ <= occ - CNT_W'(1);
      end
    end
  end

  // Statistics saturate at all-ones and do not wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_cnt <= '0;
      dropped_cnt  <= '0;
    end else if (push_fire) begin
      if (in_keep) begin
        if (accepted_cnt != {STAT_W{1'b1}}) begin
          accepted_cnt <= accepted_cnt + STAT_W'(1);
        end
      end else if (dropped_cnt != {STAT_W{1'b1}}) begin
        dropped_cnt <= dropped_cnt + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= pop_en && head.last;
    end
  end

endmodule

// File: tb/tb_n3l_pair_queue.sv
// Bench for n3l_pair_queue: directed phases plus random traffic.
// A queue-based reference model supplies every expected value.
module tb_n3l_pair_queue;

  localparam int DATA_W = 96;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_reference;
  logic [DATA_W-1:0] in_neighbor;
  logic              in_keep;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_reference;
  logic [DATA_W-1:0] out_neighbor;
  logic              out_pair_valid;
  logic              out_last;
  logic [ADDR_W:0]   count;
  logic [31:0]       accepted_cnt;
  logic [31:0]       dropped_cnt;
  logic              done;

  n3l_pair_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reference(in_reference), .in_neighbor(in_neighbor),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reference(out_reference), .out_neighbor(out_neighbor),
    .out_pair_valid(out_pair_valid), .out_last(out_last),
    .count(count), .accepted_cnt(accepted_cnt), .dropped_cnt(dropped_cnt),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] n;
    logic              pv;
    logic              last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks   = 0;
  int          failures = 0;
  bit          armed    = 0;
  int          sz;
  logic [31:0] m_acc;
  logic [31:0] m_drp;
  logic        m_done;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard monitor: compare the DUT state to the model, then advance the model.
  always @(negedge clk) begin
    if (armed) begin
      sz = exp_q.size();
      chk("count", 96'(count), 96'(sz));
      chk("in_ready", 96'(in_ready), 96'(sz != DEPTH));
      chk("out_valid", 96'(out_valid), 96'(sz != 0));
      chk("accepted_cnt", 96'(accepted_cnt), 96'(m_acc));
      chk("dropped_cnt", 96'(dropped_cnt), 96'(m_drp));
      chk("done", 96'(done), 96'(m_done));
      if (sz != 0) begin
        chk("out_pair_valid", 96'(out_pair_valid), 96'(exp_q[0].pv));
        chk("out_last", 96'(out_last), 96'(exp_q[0].last));
        if (exp_q[0].pv) begin
          chk("out_reference", out_reference, exp_q[0].r);
          chk("out_neighbor", out_neighbor, exp_q[0].n);
        end
      end
    end
    if (rst === 1'b1) begin
      exp_q.delete();
      m_acc  = '0;
      m_drp  = '0;
      m_done = 1'b0;
      armed  = 1;
    end else if (armed) begin
      sz     = exp_q.size();
      m_done = 1'b0;
      if (sz != 0 && out_ready) begin
        e = exp_q.pop_front();
        m_done = e.last;
      end
      if (in_valid && sz != DEPTH) begin
        if (in_keep) begin
          if (m_acc != 32'hFFFF_FFFF) m_acc = m_acc + 32'd1;
          exp_q.push_back('{r: in_reference, n: in_neighbor, pv: 1'b1, last: in_last});
        end else begin
          if (m_drp != 32'hFFFF_FFFF) m_drp = m_drp + 32'd1;
          if (in_last) exp_q.push_back('{r: in_reference, n: in_neighbor, pv: 1'b0, last: 1'b1});
        end
      end
    end
  end

  // Called at posedge+1. Holds the pair until it is accepted, then returns at posedge+1.
  task automatic send(input logic [95:0] r, input logic [95:0] n, input logic k, input logic l);
    int waited = 0;
    in_reference = r;
    in_neighbor  = n;
    in_keep      = k;
    in_last      = l;
    in_valid     = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 200) begin
      failures++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (out_valid !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 100) begin
      failures++;
      $display("FAIL drain_timeout: out_valid %b, required 0", out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      in_valid     = 1'($urandom());
      in_keep      = 1'($urandom());
      in_last      = 1'($urandom());
      out_ready    = 1'($urandom());
      in_reference = rnd96();
      in_neighbor  = rnd96();
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_keep = 1'b0; in_last = 1'b0; in_reference = '0; in_neighbor = '0;
    #1;
    do_reset();
    @(negedge clk);
    chk("reset_count", 96'(count), 96'(0));
    chk("reset_in_ready", 96'(in_ready), 96'(1));
    chk("reset_out_valid", 96'(out_valid), 96'(0));
    @(posedge clk); #1;

    // Filtering: neighbor x = 1..5, keep = 1,0,1,1,0
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      logic [95:0] nb;
      nb = rnd96();
      nb[31:0] = 32'(i);
      send(rnd96(), nb, (i == 1 || i == 3 || i == 4), 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("filter_accepted", 96'(accepted_cnt), 96'(3));
    chk("filter_dropped", 96'(dropped_cnt), 96'(2));
    @(posedge clk); #1;

    // Full queue and backpressure
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(rnd96(), rnd96(), 1'b1, 1'b0);
    @(negedge clk);
    chk("full_count", 96'(count), 96'(16));
    chk("full_in_ready", 96'(in_ready), 96'(0));
    @(posedge clk); #1;
    in_reference = rnd96(); in_neighbor = rnd96(); in_keep = 1'b1; in_last = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_count", 96'(count), 96'(16));
    chk("held_accepted", 96'(accepted_cnt), 96'(19));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_in_ready", 96'(in_ready), 96'(1));
    chk("after_pop_count", 96'(count), 96'(15));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("refill_count", 96'(count), 96'(16));
    chk("refill_accepted", 96'(accepted_cnt), 96'(20));
    @(posedge clk); #1;
    drain();

    // Dropped sweep end becomes a marker entry
    send(rnd96(), rnd96(), 1'b0, 1'b1);
    @(negedge clk);
    chk("marker_count", 96'(count), 96'(1));
    chk("marker_pair_valid", 96'(out_pair_valid), 96'(0));
    chk("marker_last", 96'(out_last), 96'(1));
    chk("marker_dropped", 96'(dropped_cnt), 96'(3));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", 96'(done), 96'(1));
    @(negedge clk);
    chk("done_cleared", 96'(done), 96'(0));
    @(posedge clk); #1;

    // Streaming across pointer wrap with occupancy held at 8
    for (int i = 0; i < 8; i++) send(rnd96(), rnd96(), 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      in_reference = rnd96(); in_neighbor = rnd96(); in_keep = 1'b1; in_last = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("stream_count", 96'(count), 96'(8));
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stream_end_count", 96'(count), 96'(8));
    @(posedge clk); #1;
    drain();

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 149) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_keep      = ($urandom_range(0, 2) != 0);
      in_last      = ($urandom_range(0, 4) == 0);
      out_ready    = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 8));
      in_reference = rnd96();
      in_neighbor  = rnd96();
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    drain();

    // Reset mid-stream at count 5, accepted 12
    do_reset();
    for (int i = 0; i < 12; i++) send(rnd96(), rnd96(), 1'b1, 1'b0);
    out_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_count", 96'(count), 96'(5));
    chk("pre_reset_accepted", 96'(accepted_cnt), 96'(12));
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_keep = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("midreset_count", 96'(count), 96'(0));
    chk("midreset_out_valid", 96'(out_valid), 96'(0));
    chk("midreset_in_ready", 96'(in_ready), 96'(1));
    chk("midreset_accepted", 96'(accepted_cnt), 96'(0));
    chk("midreset_dropped", 96'(dropped_cnt), 96'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(rnd96(), rnd96(), 1'b1, (i == 2));
    drain();

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/n3l_pair_queue.md
Name: n3l_pair_queue

Overview:
Downstream stage of the Newton's-third-law pair filter in the MD force path. It takes each candidate (reference, neighbor) position pair together with the filter's keep decision. Kept pairs go into a first-word-fall-through queue, and rejected pairs are discarded. Surviving pairs are handed to the force pipeline under a valid/ready handshake, with end-of-sweep markers preserved and accept/drop statistics counted.

Parameters:
DATA_W, 96, width of one packed 3x32-bit position (x at [31:0], y at [63:32], z at [95:64])
DEPTH, 16, queue entries; must be a power of two
ADDR_W, 4, log2(DEPTH)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream has a candidate pair
in_ready  out  1  block can take a pair this cycle
in_reference  in  DATA_W  reference particle position
in_neighbor  in  DATA_W  neighbor particle position
in_keep  in  1  filter decision: 1 = compute this pair, 0 = discard
in_last  in  1  final pair of the current neighbor-cell sweep
out_valid  out  1  queue head is presented
out_ready  in  1  force pipeline takes the head
out_reference  out  DATA_W  head reference position
out_neighbor  out  DATA_W  head neighbor position
out_pair_valid  out  1  1 = real pair; 0 = marker-only entry (ignore payload)
out_last  out  1  head closes a sweep
count  out  ADDR_W+1  current occupancy, 0..DEPTH
accepted_cnt  out  32  pairs enqueued with in_keep=1
dropped_cnt  out  32  pairs received with in_keep=0
done  out  1  one-cycle pulse when an out_last entry is popped

Behaviour:
- Decided interface: one clock (clk); reset rst is synchronous and active-high.
- Input handshake fires when in_valid && in_ready.
  - in_ready = (count != DEPTH). It is purely occupancy-based and does not depend on in_keep.
- Action on an input handshake:
  - keep=1: enqueue {ref, nbr, pair_valid=1, last=in_last}; accepted_cnt += 1.
  - keep=0, last=0: nothing enqueued; dropped_cnt += 1.
  - keep=0, last=1: enqueue marker {ref, nbr, pair_valid=0, last=1}; dropped_cnt += 1.
  - The sweep boundary is never lost.
- Output:
  - Storage is a circular buffer with write pointer, read pointer and count.
  - out_valid = (count != 0).
  - Head fields are driven combinationally from the read-pointer entry (FWFT).
  - Pop fires when out_valid && out_ready; the read pointer advances.
- Latency: a pair enqueued in cycle N is at the head with out_valid=1 in cycle N+1 if the queue was empty. Otherwise it follows strict FIFO order.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
  - Legal at any occupancy 1..DEPTH-1.
  - At DEPTH, in_ready=0, so only the pop occurs and in_ready rises the next cycle.
- Empty queue: out_ready is ignored, and pointers and count hold. With an empty queue a push is not bypassed; the pair appears the next cycle.
- Pointers wrap modulo DEPTH.
- count increments on push-only and decrements on pop-only. It never exceeds DEPTH and never underflows.
- Statistics counters saturate at 32'hFFFF_FFFF and do not wrap.
- done is registered: it is 1 in the cycle after a pop whose out_last=1, otherwise 0.
- Reset, including mid-operation, takes effect on the next clock edge:
  - read/write pointers, count, accepted_cnt, dropped_cnt and done go to 0;
  - out_valid=0 and in_ready=1 follow from count;
  - queue memory is not cleared, and any in-flight handshake in the reset cycle is ignored.
- Payload fields are passed bit-exact. There is no arithmetic on positions.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> count=0, out_valid=0, in_ready=1, accepted_cnt=0, dropped_cnt=0, done=0.
- Filtering: out_ready=1; 5 pairs with neighbor x = 1..5 and keep=1,0,1,1,0 -> outputs x=1,3,4 in order, each one cycle after its input; accepted_cnt=3, dropped_cnt=2.
- Full/backpressure: out_ready=0; push 16 keep pairs -> count=16, in_ready=0; a 17th pair is held and not counted. Pulse out_ready 1 cycle -> entry 0 pops, in_ready=1 next cycle, and the 17th enqueues.
- Dropped sweep end: pair keep=0, last=1 -> one entry with out_pair_valid=0, out_last=1; dropped_cnt+1; done=1 for exactly one cycle after its pop.
- Wrap and concurrency: steady streaming of 40 keep pairs with out_ready toggling 1,0 and count held near 8 -> no loss or reorder across pointer wrap; count unchanged on push+pop cycles.
- Reset mid-stream at count=5 with accepted_cnt=12 -> next cycle count=0, out_valid=0, counters 0; subsequent pairs flow normally.
